// File: rtl/clock_replacement_state_pkg.sv
// Shared cache package: replacement FSM states, hand reset value
// and the one-hot rotate used to advance the clock hand.
package clock_replacement_state_pkg;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } crs_state_e;

    localparam int MAX_WAYS = 64;

    // Hand points at way 0 out of reset.
    localparam logic [MAX_WAYS-1:0] HAND_RST = MAX_WAYS'(1);

    function automatic logic [MAX_WAYS-1:0] rotl1(
        input logic [MAX_WAYS-1:0] m,
        input int                  w
    );
        logic [MAX_WAYS-1:0] wmask;
        logic [MAX_WAYS-1:0] r;
        if (w >= MAX_WAYS)
            wmask = '1;
        else
            wmask = (MAX_WAYS'(1) << w) - MAX_WAYS'(1);
        r = (m << 1) | (m >> (w - 1));
        return r & wmask;
    endfunction

endpackage

// File: rtl/clock_replacement_state_policy.sv
// CLOCK replacement policy: sweep from the hand, clearing used ways,
// and pick the first unused way (the hand way if all are used).
module ClockReplacement #(
    parameter int ASSOCITIVITY = 2
) (
    input  logic [ASSOCITIVITY-1:0] i_hand,
    input  logic [ASSOCITIVITY-1:0] i_use,
    output logic [ASSOCITIVITY-1:0] o_victim_mask,
    output logic [ASSOCITIVITY-1:0] o_use_if_evict
);

    localparam int IW = (ASSOCITIVITY > 1) ? $clog2(ASSOCITIVITY) : 1;

    logic [IW-1:0]           w_hidx;
    logic [IW-1:0]           w_idx;
    logic                    w_found;
    logic [ASSOCITIVITY-1:0] w_victim;
    logic [ASSOCITIVITY-1:0] w_uie;

    always_comb begin
        w_hidx   = '0;
        w_idx    = '0;
        w_found  = 1'b0;
        w_victim = '0;
        w_uie    = i_use;
        for (int i = 0; i < ASSOCITIVITY; i++) begin
            if (i_hand[i])
                w_hidx = IW'(i);
        end
        for (int k = 0; k < ASSOCITIVITY; k++) begin
            w_idx = IW'((int'(w_hidx) + k) % ASSOCITIVITY);
            if (!w_found) begin
                if (!i_use[w_idx]) begin
                    w_found         = 1'b1;
                    w_victim[w_idx] = 1'b1;
                end else begin
                    w_uie[w_idx] = 1'b0;
                end
            end
        end
        // Full sweep: every use bit already cleared, hand way is evicted.
        if (!w_found)
            w_victim[w_hidx] = 1'b1;
    end

    assign o_victim_mask  = w_victim;
    assign o_use_if_evict = w_uie;

endmodule

// File: rtl/clock_replacement_state.sv
// Per-set CLOCK hand/use storage with a one-deep victim request FSM;
// hits set use bits, fill commit advances the hand and applies the sweep.
module clock_replacement_state
    import clock_replacement_state_pkg::*;
#(
    parameter  int ASSOCITIVITY = 2,
    parameter  int NUM_SETS     = 16,
    localparam int SET_W        = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_hit_valid,
    input  logic [SET_W-1:0]        i_hit_set,
    input  logic [ASSOCITIVITY-1:0] i_hit_way_mask,
    input  logic                    i_victim_req,
    input  logic [SET_W-1:0]        i_victim_set,
    output logic                    o_victim_ready,
    output logic                    o_victim_valid,
    output logic [ASSOCITIVITY-1:0] o_victim_mask,
    input  logic                    i_fill_commit,
    input  logic                    i_victim_cancel
);

    localparam logic [ASSOCITIVITY-1:0] HAND0 = HAND_RST[ASSOCITIVITY-1:0];

    crs_state_e              r_state;
    logic [ASSOCITIVITY-1:0] r_hand [NUM_SETS];
    logic [ASSOCITIVITY-1:0] r_use  [NUM_SETS];
    logic [ASSOCITIVITY-1:0] r_vmask;
    logic [ASSOCITIVITY-1:0] r_clear;
    logic [SET_W-1:0]        r_vset;

    logic                    w_hit_ok;
    logic                    w_vset_ok;
    logic                    w_accept;
    logic                    w_commit;
    logic [ASSOCITIVITY-1:0] w_rd_hand;
    logic [ASSOCITIVITY-1:0] w_rd_use;
    logic [ASSOCITIVITY-1:0] w_pol_victim;
    logic [ASSOCITIVITY-1:0] w_pol_uie;
    logic [MAX_WAYS-1:0]     w_rot;
    logic [ASSOCITIVITY-1:0] w_next_hand;
    logic [ASSOCITIVITY-1:0] w_nhand [NUM_SETS];
    logic [ASSOCITIVITY-1:0] w_nuse  [NUM_SETS];

    // Indices beyond NUM_SETS only exist for non-power-of-two set counts.
    assign w_hit_ok  = i_hit_valid &&
                       ({1'b0, i_hit_set} < (SET_W+1)'(NUM_SETS));
    assign w_vset_ok = {1'b0, i_victim_set} < (SET_W+1)'(NUM_SETS);

    assign w_accept = (r_state == ST_IDLE) && i_victim_req && w_vset_ok;
    assign w_commit = (r_state == ST_PENDING) && i_fill_commit;

    always_comb begin
        w_rd_hand = HAND0;
        w_rd_use  = '0;
        if (w_vset_ok) begin
            w_rd_hand = r_hand[i_victim_set];
            w_rd_use  = r_use[i_victim_set];
            if (w_hit_ok && (i_hit_set == i_victim_set))
                w_rd_use = w_rd_use | i_hit_way_mask;
        end
    end

    ClockReplacement #(
        .ASSOCITIVITY(ASSOCITIVITY)
    ) u_policy (
        .i_hand        (w_rd_hand),
        .i_use         (w_rd_use),
        .o_victim_mask (w_pol_victim),
        .o_use_if_evict(w_pol_uie)
    );

    assign w_rot       = rotl1(MAX_WAYS'(r_vmask), ASSOCITIVITY);
    assign w_next_hand = w_rot[ASSOCITIVITY-1:0];

    // Commit clears first, then a same-cycle hit is OR'd back in.
    always_comb begin
        for (int s = 0; s < NUM_SETS; s++) begin
            w_nhand[s] = r_hand[s];
            w_nuse[s]  = r_use[s];
            if (w_commit && (r_vset == SET_W'(s))) begin
                w_nhand[s] = w_next_hand;
                w_nuse[s]  = (r_use[s] & ~r_clear) | r_vmask;
            end
            if (w_hit_ok && (i_hit_set == SET_W'(s)))
                w_nuse[s] = w_nuse[s] | i_hit_way_mask;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                r_hand[s] <= HAND0;
                r_use[s]  <= '0;
            end
        end else begin
            for (int s = 0; s < NUM_SETS; s++) begin
                r_hand[s] <= w_nhand[s];
                r_use[s]  <= w_nuse[s];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_vmask <= '0;
            r_clear <= '0;
            r_vset  <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= ST_PENDING;
                        r_vmask <= w_pol_victim;
                        r_vset  <= i_victim_set;
                        r_clear <= w_rd_use & ~w_pol_uie;
                    end
                end
                ST_PENDING: begin
                    if (i_fill_commit || i_victim_cancel) begin
                        r_state <= ST_IDLE;
                        r_vmask <= '0;
                        r_clear <= '0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_victim_ready = (r_state == ST_IDLE);
    assign o_victim_valid = (r_state == ST_PENDING);
    assign o_victim_mask  = r_vmask;

endmodule

// File: tb/tb_clock_replacement_state.sv
// Directed bench for clock_replacement_state (4 ways, 4 sets);
// set state is observed through the DUT's storage arrays.
module tb_clock_replacement_state;

    localparam int A  = 4;
    localparam int NS = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         hit_valid;
    logic [1:0]   hit_set;
    logic [A-1:0] hit_mask;
    logic         vreq;
    logic [1:0]   vset;
    logic         vready;
    logic         vvalid;
    logic [A-1:0] vmask;
    logic         commit;
    logic         cancel;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    clock_replacement_state #(
        .ASSOCITIVITY(A),
        .NUM_SETS    (NS)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_hit_valid    (hit_valid),
        .i_hit_set      (hit_set),
        .i_hit_way_mask (hit_mask),
        .i_victim_req   (vreq),
        .i_victim_set   (vset),
        .o_victim_ready (vready),
        .o_victim_valid (vvalid),
        .o_victim_mask  (vmask),
        .i_fill_commit  (commit),
        .i_victim_cancel(cancel)
    );

    task automatic idle_inputs();
        hit_valid = 1'b0;
        hit_set   = '0;
        hit_mask  = '0;
        vreq      = 1'b0;
        vset      = '0;
        commit    = 1'b0;
        cancel    = 1'b0;
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_hit(input logic [1:0] s, input logic [A-1:0] m);
        hit_valid = 1'b1;
        hit_set   = s;
        hit_mask  = m;
        cyc();
        idle_inputs();
    endtask

    task automatic do_req(input logic [1:0] s);
        vreq = 1'b1;
        vset = s;
        cyc();
        idle_inputs();
    endtask

    task automatic do_commit();
        commit = 1'b1;
        cyc();
        idle_inputs();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        cyc();
        checks++;
        if (vready !== 1'b1 || vvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs: ready=%b valid=%b want 1/0", vready, vvalid);
        end
        checks++;
        if (vmask !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mask: got %b want 0000", vmask);
        end
        checks++;
        if (dut.r_hand[2] !== 4'b0001 || dut.r_use[2] !== 4'b0000) begin
            errors++;
            $display("FAIL reset_set2: hand=%b use=%b want 0001/0000",
                     dut.r_hand[2], dut.r_use[2]);
        end
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_first_victim();
        do_req(2'd2);
        checks++;
        if (vvalid !== 1'b1 || vready !== 1'b0 || vmask !== 4'b0001) begin
            errors++;
            $display("FAIL first_req: valid=%b ready=%b mask=%b want 1/0/0001",
                     vvalid, vready, vmask);
        end
        do_commit();
        checks++;
        if (dut.r_hand[2] !== 4'b0010 || dut.r_use[2] !== 4'b0001) begin
            errors++;
            $display("FAIL first_commit: hand=%b use=%b want 0010/0001",
                     dut.r_hand[2], dut.r_use[2]);
        end
        checks++;
        if (vready !== 1'b1 || vvalid !== 1'b0) begin
            errors++;
            $display("FAIL first_idle: ready=%b valid=%b want 1/0", vready, vvalid);
        end
    endtask

    task automatic test_all_used();
        for (int w = 0; w < A; w++)
            do_hit(2'd0, 4'b0001 << w);
        checks++;
        if (dut.r_use[0] !== 4'b1111) begin
            errors++;
            $display("FAIL allused_hits: use=%b want 1111", dut.r_use[0]);
        end
        do_req(2'd0);
        checks++;
        if (vmask !== 4'b0001) begin
            errors++;
            $display("FAIL allused_mask: got %b want 0001", vmask);
        end
        do_commit();
        checks++;
        if (dut.r_hand[0] !== 4'b0010 || dut.r_use[0] !== 4'b0001) begin
            errors++;
            $display("FAIL allused_commit: hand=%b use=%b want 0010/0001",
                     dut.r_hand[0], dut.r_use[0]);
        end
    endtask

    task automatic test_partial_clear();
        do_hit(2'd1, 4'b0001);
        do_req(2'd1);
        checks++;
        if (vmask !== 4'b0010) begin
            errors++;
            $display("FAIL part_mask1: got %b want 0010", vmask);
        end
        do_commit();
        checks++;
        if (dut.r_hand[1] !== 4'b0100 || dut.r_use[1] !== 4'b0010) begin
            errors++;
            $display("FAIL part_commit1: hand=%b use=%b want 0100/0010",
                     dut.r_hand[1], dut.r_use[1]);
        end
        do_hit(2'd1, 4'b1100);
        checks++;
        if (dut.r_use[1] !== 4'b1110) begin
            errors++;
            $display("FAIL part_multihot: use=%b want 1110", dut.r_use[1]);
        end
        do_req(2'd1);
        checks++;
        if (vmask !== 4'b0001) begin
            errors++;
            $display("FAIL part_mask2: got %b want 0001", vmask);
        end
        do_commit();
        checks++;
        if (dut.r_hand[1] !== 4'b0010 || dut.r_use[1] !== 4'b0011) begin
            errors++;
            $display("FAIL part_commit2: hand=%b use=%b want 0010/0011",
                     dut.r_hand[1], dut.r_use[1]);
        end
    endtask

    task automatic test_hit_in_commit();
        do_req(2'd1);
        checks++;
        if (vmask !== 4'b0100) begin
            errors++;
            $display("FAIL hic_mask: got %b want 0100", vmask);
        end
        do_hit(2'd1, 4'b0010);
        do_req(2'd0);
        checks++;
        if (vvalid !== 1'b1 || vmask !== 4'b0100) begin
            errors++;
            $display("FAIL hic_req_ignored: valid=%b mask=%b want 1/0100",
                     vvalid, vmask);
        end
        commit    = 1'b1;
        hit_valid = 1'b1;
        hit_set   = 2'd1;
        hit_mask  = 4'b1000;
        cyc();
        idle_inputs();
        checks++;
        if (dut.r_hand[1] !== 4'b1000 || dut.r_use[1] !== 4'b1101) begin
            errors++;
            $display("FAIL hic_commit: hand=%b use=%b want 1000/1101",
                     dut.r_hand[1], dut.r_use[1]);
        end
    endtask

    task automatic test_commit_other_set();
        do_req(2'd2);
        checks++;
        if (vmask !== 4'b0010) begin
            errors++;
            $display("FAIL other_mask: got %b want 0010", vmask);
        end
        commit    = 1'b1;
        hit_valid = 1'b1;
        hit_set   = 2'd3;
        hit_mask  = 4'b0100;
        cyc();
        idle_inputs();
        checks++;
        if (dut.r_hand[2] !== 4'b0100 || dut.r_use[2] !== 4'b0011) begin
            errors++;
            $display("FAIL other_set2: hand=%b use=%b want 0100/0011",
                     dut.r_hand[2], dut.r_use[2]);
        end
        checks++;
        if (dut.r_hand[3] !== 4'b0001 || dut.r_use[3] !== 4'b0100) begin
            errors++;
            $display("FAIL other_set3: hand=%b use=%b want 0001/0100",
                     dut.r_hand[3], dut.r_use[3]);
        end
        do_hit(2'd3, 4'b0000);
        checks++;
        if (dut.r_use[3] !== 4'b0100) begin
            errors++;
            $display("FAIL zero_hit: use=%b want 0100", dut.r_use[3]);
        end
    endtask

    task automatic test_cancel();
        do_req(2'd0);
        checks++;
        if (vmask !== 4'b0010) begin
            errors++;
            $display("FAIL cancel_mask: got %b want 0010", vmask);
        end
        cancel = 1'b1;
        cyc();
        idle_inputs();
        checks++;
        if (vready !== 1'b1 || vvalid !== 1'b0 || vmask !== 4'b0000) begin
            errors++;
            $display("FAIL cancel_hs: ready=%b valid=%b mask=%b want 1/0/0000",
                     vready, vvalid, vmask);
        end
        checks++;
        if (dut.r_hand[0] !== 4'b0010 || dut.r_use[0] !== 4'b0001) begin
            errors++;
            $display("FAIL cancel_state: hand=%b use=%b want 0010/0001",
                     dut.r_hand[0], dut.r_use[0]);
        end
        do_req(2'd0);
        commit = 1'b1;
        cancel = 1'b1;
        cyc();
        idle_inputs();
        checks++;
        if (dut.r_hand[0] !== 4'b0100 || dut.r_use[0] !== 4'b0011) begin
            errors++;
            $display("FAIL commit_wins: hand=%b use=%b want 0100/0011",
                     dut.r_hand[0], dut.r_use[0]);
        end
    endtask

    task automatic test_async_reset();
        int bad;
        do_req(2'd1);
        checks++;
        if (vvalid !== 1'b1 || vmask !== 4'b0010) begin
            errors++;
            $display("FAIL arst_pre: valid=%b mask=%b want 1/0010", vvalid, vmask);
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (vvalid !== 1'b0 || vready !== 1'b1 || vmask !== 4'b0000) begin
            errors++;
            $display("FAIL arst_hs: valid=%b ready=%b mask=%b want 0/1/0000",
                     vvalid, vready, vmask);
        end
        bad = 0;
        for (int s = 0; s < NS; s++)
            if (dut.r_hand[s] !== 4'b0001 || dut.r_use[s] !== 4'b0000)
                bad++;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL arst_sets: %0d sets not at reset value want 0", bad);
        end
        cyc();
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_bypass();
        do_hit(2'd0, 4'b1110);
        hit_valid = 1'b1;
        hit_set   = 2'd0;
        hit_mask  = 4'b0001;
        vreq      = 1'b1;
        vset      = 2'd0;
        cyc();
        idle_inputs();
        checks++;
        if (vmask !== 4'b0001 || dut.r_use[0] !== 4'b1111) begin
            errors++;
            $display("FAIL bypass_req: mask=%b use=%b want 0001/1111",
                     vmask, dut.r_use[0]);
        end
        do_commit();
        checks++;
        if (dut.r_hand[0] !== 4'b0010 || dut.r_use[0] !== 4'b0001) begin
            errors++;
            $display("FAIL bypass_commit: hand=%b use=%b want 0010/0001",
                     dut.r_hand[0], dut.r_use[0]);
        end
    endtask

    initial begin
        test_reset();
        test_first_victim();
        test_all_used();
        test_partial_clear();
        test_hit_in_commit();
        test_commit_other_set();
        test_cancel();
        test_async_reset();
        test_bypass();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
